// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Desc     : Unit indices, op codes, operand-need masks and FSM encoding shared
//            by the FP issue controller.
// Revision : 1.0
// ============================================================================
package fpu_pkg;

    localparam int N_UNITS = 7;

    localparam logic [2:0] U_ADDSUB  = 3'd0;
    localparam logic [2:0] U_MUL     = 3'd1;
    localparam logic [2:0] U_DIV     = 3'd2;
    localparam logic [2:0] U_COMP    = 3'd3;
    localparam logic [2:0] U_FCVTSW  = 3'd4;
    localparam logic [2:0] U_FCVTWS  = 3'd5;
    localparam logic [2:0] U_FSQRTS  = 3'd6;
    localparam logic [2:0] U_ILLEGAL = 3'd7;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_EQ  = 8'h14;
    localparam logic [7:0] OP_LT  = 8'h0C;
    localparam logic [7:0] OP_LE  = 8'h1C;

    // Bit i set when unit i consumes that operand channel
    localparam logic [N_UNITS-1:0] NEEDS_B  = 7'b0001111;
    localparam logic [N_UNITS-1:0] NEEDS_OP = 7'b0001001;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_SEND = 5'b00010,
        S_WAIT = 5'b00100,
        S_DONE = 5'b01000,
        S_FAIL = 5'b10000
    } state_t;

    function automatic logic [N_UNITS-1:0] unit_onehot(input logic [2:0] u);
        logic [N_UNITS-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (u == 3'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_ctrl_if
// Desc     : AXI4-Stream operand/result bundle between issue controller and
//            the FP units.
// Revision : 1.0
// ============================================================================
interface fpu_issue_ctrl_if #(
    parameter int DATA_W    = 32,
    parameter int NUM_UNITS = 7
);
    logic [DATA_W-1:0]           A_TDATA;
    logic [DATA_W-1:0]           B_TDATA;
    logic [7:0]                  OP_TDATA;
    logic [NUM_UNITS-1:0]        A_TVALID;
    logic [NUM_UNITS-1:0]        B_TVALID;
    logic [NUM_UNITS-1:0]        OP_TVALID;
    logic [NUM_UNITS-1:0]        A_TREADY;
    logic [NUM_UNITS-1:0]        B_TREADY;
    logic [NUM_UNITS-1:0]        OP_TREADY;
    logic [NUM_UNITS*DATA_W-1:0] R_TDATA;
    logic [NUM_UNITS-1:0]        R_TVALID;
    logic [NUM_UNITS-1:0]        R_TREADY;

    modport master (
        output A_TDATA, B_TDATA, OP_TDATA, A_TVALID, B_TVALID, OP_TVALID, R_TREADY,
        input  A_TREADY, B_TREADY, OP_TREADY, R_TDATA, R_TVALID
    );

    modport slave (
        input  A_TDATA, B_TDATA, OP_TDATA, A_TVALID, B_TVALID, OP_TVALID, R_TREADY,
        output A_TREADY, B_TREADY, OP_TREADY, R_TDATA, R_TVALID
    );

endinterface
`default_nettype wire

// File: rtl/axis_src_hold.sv
`default_nettype none
// ============================================================================
// Module   : axis_src_hold
// Desc     : One operand channel: per-unit TVALID plus shared TDATA, held until
//            the selected unit accepts it.
// Revision : 1.0
// ============================================================================
module axis_src_hold #(
    parameter int DATA_W    = 32,
    parameter int NUM_UNITS = 7
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_load,
    input  wire logic [NUM_UNITS-1:0] i_sel,
    input  wire logic [DATA_W-1:0]    i_data,
    input  wire logic                 i_abort,
    input  wire logic [NUM_UNITS-1:0] i_ready,
    output logic [NUM_UNITS-1:0]      o_valid,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_pending
);

    // Still owed after the coming edge (not accepted this cycle)
    assign o_pending = |(o_valid & ~i_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= '0;
            o_data  <= '0;
        end else if (i_abort) begin
            o_valid <= '0;
        end else if (i_load) begin
            o_valid <= i_sel;
            o_data  <= i_data;
        end else if (|(o_valid & i_ready)) begin
            o_valid <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_ctrl
// Desc     : Issues one FP operation at a time to the selected AXI4-Stream FP
//            unit, collects its result and reports DONE/ERR to the core.
// Revision : 1.0
// ============================================================================
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int NUM_UNITS      = 7,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    input  wire logic              START,
    input  wire logic [2:0]        UNIT,
    input  wire logic [7:0]        SUBOP,
    input  wire logic [DATA_W-1:0] SRC_A,
    input  wire logic [DATA_W-1:0] SRC_B,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR,
    output logic [DATA_W-1:0]      RESULT,
    fpu_issue_ctrl_if.master       axis
);

    state_t               r_state;
    logic [NUM_UNITS-1:0] r_sel;
    logic [NUM_UNITS-1:0] r_r_ready;
    logic [CNT_W-1:0]     r_cnt;

    logic [NUM_UNITS-1:0] w_sel;
    logic                 w_in_idle;
    logic                 w_accept;
    logic                 w_illegal;
    logic                 w_active;
    logic                 w_result;
    logic                 w_timeout;
    logic                 w_a_left;
    logic                 w_b_left;
    logic                 w_op_left;
    logic [DATA_W-1:0]    w_r_data;

    assign w_sel     = unit_onehot(UNIT);
    assign w_in_idle = (r_state == S_IDLE);
    assign w_accept  = w_in_idle && START && (UNIT != U_ILLEGAL);
    assign w_illegal = w_in_idle && START && (UNIT == U_ILLEGAL);
    assign w_active  = (r_state == S_SEND) || (r_state == S_WAIT);
    assign w_result  = (r_state == S_WAIT) && |(axis.R_TVALID & r_sel);
    // A result accepted on the final cycle has already been handshaken, so keep it
    assign w_timeout = w_active && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !w_result;

    always_comb begin
        w_r_data = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (r_sel[i]) w_r_data = w_r_data | axis.R_TDATA[i*DATA_W +: DATA_W];
        end
    end

    axis_src_hold #(.DATA_W(DATA_W), .NUM_UNITS(NUM_UNITS)) u_src_a (
        .clk(CLK), .rst(RST), .i_load(w_accept), .i_sel(w_sel), .i_data(SRC_A),
        .i_abort(w_timeout), .i_ready(axis.A_TREADY),
        .o_valid(axis.A_TVALID), .o_data(axis.A_TDATA), .o_pending(w_a_left)
    );

    axis_src_hold #(.DATA_W(DATA_W), .NUM_UNITS(NUM_UNITS)) u_src_b (
        .clk(CLK), .rst(RST), .i_load(w_accept), .i_sel(w_sel & NEEDS_B), .i_data(SRC_B),
        .i_abort(w_timeout), .i_ready(axis.B_TREADY),
        .o_valid(axis.B_TVALID), .o_data(axis.B_TDATA), .o_pending(w_b_left)
    );

    axis_src_hold #(.DATA_W(8), .NUM_UNITS(NUM_UNITS)) u_src_op (
        .clk(CLK), .rst(RST), .i_load(w_accept), .i_sel(w_sel & NEEDS_OP), .i_data(SUBOP),
        .i_abort(w_timeout), .i_ready(axis.OP_TREADY),
        .o_valid(axis.OP_TVALID), .o_data(axis.OP_TDATA), .o_pending(w_op_left)
    );

    assign axis.R_TREADY = r_r_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_r_ready <= '0;
            r_cnt     <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            RESULT    <= '0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_SEND;
                        r_sel   <= w_sel;
                        r_cnt   <= '0;
                        BUSY    <= 1'b1;
                    end else if (w_illegal) begin
                        r_state <= S_FAIL;
                        ERR     <= 1'b1;
                        RESULT  <= '0;
                        BUSY    <= 1'b1;
                    end
                end
                S_SEND: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_timeout) begin
                        r_state <= S_FAIL;
                        ERR     <= 1'b1;
                        RESULT  <= '0;
                    end else if (!(w_a_left || w_b_left || w_op_left)) begin
                        r_state   <= S_WAIT;
                        r_r_ready <= r_sel;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_result) begin
                        r_state   <= S_DONE;
                        DONE      <= 1'b1;
                        RESULT    <= w_r_data;
                        r_r_ready <= '0;
                    end else if (w_timeout) begin
                        r_state   <= S_FAIL;
                        ERR       <= 1'b1;
                        RESULT    <= '0;
                        r_r_ready <= '0;
                    end
                end
                S_DONE, S_FAIL: begin
                    r_state <= S_IDLE;
                    BUSY    <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_r_ready <= '0;
                    BUSY      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_issue_ctrl
// Desc     : Scoreboard bench for fpu_issue_ctrl with a behavioural unit model.
// Revision : 1.0
// ============================================================================
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam int DW = 32;
    localparam int NU = 7;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic [2:0]    UNIT;
    logic [7:0]    SUBOP;
    logic [DW-1:0] SRC_A;
    logic [DW-1:0] SRC_B;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic [DW-1:0] RESULT;

    fpu_issue_ctrl_if #(.DATA_W(DW), .NUM_UNITS(NU)) axis ();

    fpu_issue_ctrl #(.DATA_W(DW), .NUM_UNITS(NU), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .START(START), .UNIT(UNIT), .SUBOP(SUBOP),
        .SRC_A(SRC_A), .SRC_B(SRC_B), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .RESULT(RESULT), .axis(axis)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_err;
        logic [31:0] result;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  op;
        int          n_a;
        int          n_b;
        int          n_op;
        int          due;
        int          a_vcyc;
        int          b_vcyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          cur_unit = 7;
    logic [6:0]  cur_sel = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int          n_a, n_b, n_op, n_r, a_vcyc, b_vcyc;
    logic [31:0] a_seen, b_seen, last_result;
    logic [7:0]  op_seen;
    bit          resp_prev, pa_hold, pb_hold, pop_hold;
    logic [38:0] pa, pb;
    logic [14:0] pop;

    always @(negedge CLK) begin : mon
        exp_t       e;
        logic [6:0] b_allow, op_allow;
        if (RST) begin
            n_a = 0; n_b = 0; n_op = 0; n_r = 0; a_vcyc = 0; b_vcyc = 0;
            resp_prev = 0; pa_hold = 0; pb_hold = 0; pop_hold = 0;
            last_result = '0;
        end else begin
            b_allow  = (cur_unit <= 3) ? cur_sel : 7'b0;
            op_allow = (cur_unit == 0 || cur_unit == 3) ? cur_sel : 7'b0;
            check("scope", {axis.A_TVALID & ~cur_sel, axis.B_TVALID & ~b_allow,
                            axis.OP_TVALID & ~op_allow, axis.R_TREADY & ~cur_sel}, 64'd0);
            check("rready_during_send", 64'(|axis.R_TREADY && |(axis.A_TVALID | axis.B_TVALID | axis.OP_TVALID)), 64'd0);
            if (pa_hold)  check("a_hold",  {axis.A_TVALID, axis.A_TDATA}, pa);
            if (pb_hold)  check("b_hold",  {axis.B_TVALID, axis.B_TDATA}, pb);
            if (pop_hold) check("op_hold", {axis.OP_TVALID, axis.OP_TDATA}, pop);
            pa_hold  = |(axis.A_TVALID & ~axis.A_TREADY);
            pb_hold  = |(axis.B_TVALID & ~axis.B_TREADY);
            pop_hold = |(axis.OP_TVALID & ~axis.OP_TREADY);
            pa  = {axis.A_TVALID, axis.A_TDATA};
            pb  = {axis.B_TVALID, axis.B_TDATA};
            pop = {axis.OP_TVALID, axis.OP_TDATA};
            if (|axis.A_TVALID) a_vcyc++;
            if (|axis.B_TVALID) b_vcyc++;
            if (|(axis.A_TVALID & axis.A_TREADY))   begin n_a++;  a_seen  = axis.A_TDATA;  end
            if (|(axis.B_TVALID & axis.B_TREADY))   begin n_b++;  b_seen  = axis.B_TDATA;  end
            if (|(axis.OP_TVALID & axis.OP_TREADY)) begin n_op++; op_seen = axis.OP_TDATA; end
            if (|(axis.R_TVALID & axis.R_TREADY)) n_r++;

            if (DONE || ERR) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_response: DONE=%0b ERR=%0b with nothing outstanding", DONE, ERR);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind", {DONE, ERR}, e.is_err ? 64'b01 : 64'b10);
                    check("result", RESULT, e.result);
                    check("busy_in_resp", BUSY, 64'd1);
                    check("hs_counts", {8'(n_a), 8'(n_b), 8'(n_op), 8'(n_r)},
                          {8'(e.n_a), 8'(e.n_b), 8'(e.n_op), 8'(e.is_err ? 0 : 1)});
                    if (e.n_a > 0)     check("a_data", a_seen, e.a);
                    if (e.n_b > 0)     check("b_data", b_seen, e.b);
                    if (e.n_op > 0)    check("op_data", op_seen, e.op);
                    if (e.due >= 0)    check("latency", cyc, e.due);
                    if (e.a_vcyc >= 0) check("a_valid_cycles", a_vcyc, e.a_vcyc);
                    if (e.b_vcyc >= 0) check("b_valid_cycles", b_vcyc, e.b_vcyc);
                    last_result = e.result;
                end
                n_a = 0; n_b = 0; n_op = 0; n_r = 0; a_vcyc = 0; b_vcyc = 0;
                resp_prev = 1;
            end else begin
                check("result_held", RESULT, last_result);
                if (resp_prev)
                    check("idle_after_resp", {BUSY, |axis.A_TVALID, |axis.B_TVALID,
                                              |axis.OP_TVALID, |axis.R_TREADY}, 64'd0);
                resp_prev = 0;
            end
        end
    end

    // ---------------- stimulus + unit model ----------------
    task automatic idle_bus();
        axis.A_TREADY  = '0;
        axis.B_TREADY  = '0;
        axis.OP_TREADY = '0;
        axis.R_TVALID  = '0;
        axis.R_TDATA   = '0;
    endtask

    task automatic drive_units(input int k, input int a_dly, input int b_dly, input int op_dly,
                               input int r_dly, input bit hang, input bit r_done, input logic [31:0] resp);
        axis.A_TREADY  = (7'($urandom) & ~cur_sel) | ((k >= a_dly)  ? cur_sel : 7'b0);
        axis.B_TREADY  = (7'($urandom) & ~cur_sel) | ((k >= b_dly)  ? cur_sel : 7'b0);
        axis.OP_TREADY = (7'($urandom) & ~cur_sel) | ((k >= op_dly) ? cur_sel : 7'b0);
        axis.R_TVALID  = (7'($urandom) & ~cur_sel) |
                         ((!hang && k >= r_dly && !r_done) ? cur_sel : 7'b0);
        for (int i = 0; i < NU; i++)
            axis.R_TDATA[i*DW +: DW] = cur_sel[i] ? resp : $urandom;
    endtask

    task automatic issue(input logic [2:0] unit, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] resp,
                         input int a_dly, input int b_dly, input int op_dly, input int r_dly,
                         input bit hang, input int stray, input bit fast,
                         input int exp_av, input int exp_bv);
        exp_t e;
        int   k;
        int   t;
        bit   got;
        bit   r_done;
        k = 0;
        while (BUSY && k < 50) begin @(negedge CLK); k++; end
        @(posedge CLK); #1;
        t        = cyc;
        cur_unit = int'(unit);
        cur_sel  = (unit <= 3'd6) ? (7'b1 << unit) : 7'b0;
        UNIT = unit; SUBOP = op; SRC_A = a; SRC_B = b; START = 1'b1;

        e.is_err = (unit == 3'd7) || hang;
        e.result = e.is_err ? 32'd0 : resp;
        e.a = a; e.b = b; e.op = op;
        e.n_a    = (unit <= 3'd6) ? 1 : 0;
        e.n_b    = (unit <= 3'd3) ? 1 : 0;
        e.n_op   = (unit == 3'd0 || unit == 3'd3) ? 1 : 0;
        e.due    = (unit == 3'd7) ? t + 1 : hang ? t + TO + 1 : fast ? t + 3 : -1;
        e.a_vcyc = exp_av;
        e.b_vcyc = exp_bv;
        exp_q.push_back(e);

        r_done = 0;
        drive_units(0, a_dly, b_dly, op_dly, r_dly, hang, r_done, resp);
        got = 0; k = 0;
        while (!got && k < 60) begin
            @(posedge CLK); #1;
            k++;
            START = 1'b0;
            if (stray == 2 || (stray == 1 && $urandom_range(0, 2) == 0)) begin
                START = 1'b1; UNIT = 3'($urandom); SUBOP = 8'($urandom);
                SRC_A = $urandom; SRC_B = $urandom;
            end
            drive_units(k, a_dly, b_dly, op_dly, r_dly, hang, r_done, resp);
            @(negedge CLK);
            if (|(axis.R_TVALID & axis.R_TREADY & cur_sel)) r_done = 1;
            if (DONE || ERR) got = 1;
        end
        START = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL op_response: none after %0d cycles, expected DONE or ERR", k);
            exp_q.delete();
        end
        idle_bus();
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; UNIT = '0; SUBOP = '0; SRC_A = '0; SRC_B = '0;
        idle_bus();
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("reset_flags", {BUSY, DONE, ERR}, 64'd0);
        check("reset_result", RESULT, 64'd0);
        check("reset_valids", {axis.A_TVALID, axis.B_TVALID, axis.OP_TVALID, axis.R_TREADY}, 64'd0);
        check("reset_tdata", {axis.A_TDATA, axis.B_TDATA[23:0], axis.OP_TDATA}, 64'd0);

        // ADDSUB sub 3.0 - 1.0 = 2.0, minimum latency
        issue(U_ADDSUB, OP_SUB, 32'h40400000, 32'h3F800000, 32'h40000000,
              1, 1, 1, 2, 0, 0, 1, 1, 1);
        // MUL with B stalled five cycles
        issue(U_MUL, 8'h00, 32'h3FC00000, 32'h40800000, 32'h40C00000,
              1, 6, 1, 1, 0, 0, 0, 1, 6);
        // FSQRTS: A only; stray results from other units are random
        issue(U_FSQRTS, 8'h00, 32'h41100000, 32'hDEADBEEF, 32'h40400000,
              1, 1, 1, 3, 0, 0, 0, 1, 0);
        // DIV that never answers
        issue(U_DIV, 8'h00, 32'h3F800000, 32'h00000000, 32'h12345678,
              1, 1, 1, 1, 1, 0, 0, -1, -1);
        // Illegal unit
        issue(3'd7, 8'h00, 32'h11111111, 32'h22222222, 32'h33333333,
              1, 1, 1, 1, 0, 0, 0, 0, 0);
        // COMP with START held high throughout
        issue(U_COMP, OP_LT, 32'hBF800000, 32'h3F800000, 32'h00000001,
              2, 3, 2, 6, 0, 2, 0, -1, -1);

        // Reset while A_TVALID[3] is pending
        @(posedge CLK); #1;
        cur_unit = 3; cur_sel = 7'b0001000;
        UNIT = U_COMP; SUBOP = OP_EQ; SRC_A = 32'hCAFEF00D; SRC_B = 32'h0BADF00D; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
        check("pre_reset_a_valid", axis.A_TVALID, 64'h08);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_flags", {BUSY, DONE, ERR}, 64'd0);
        check("rst_valids", {axis.A_TVALID, axis.B_TVALID, axis.OP_TVALID, axis.R_TREADY}, 64'd0);
        check("rst_result", RESULT, 64'd0);
        check("rst_tdata", {axis.A_TDATA, axis.B_TDATA[23:0], axis.OP_TDATA}, 64'd0);

        for (int n = 0; n < 60; n++) begin
            logic [2:0] u;
            bit         h;
            u = 3'($urandom_range(0, 7));
            h = (u != 3'd7) && ($urandom_range(0, 7) == 0);
            issue(u, 8'($urandom), $urandom, $urandom, $urandom,
                  $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                  $urandom_range(1, 5), h, $urandom_range(0, 1), 0, -1, -1);
        end

        repeat (3) @(negedge CLK);
        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL leftover_expected: %0d responses never seen, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Sequences one floating-point operation at a time onto the seven AXI4-Stream FP units (ADDSUB, MUL, DIV, COMP, FCVTSW, FCVTWS, FSQRTS). It drives operand channels with proper VALID/READY holding and collects the result. It provides a BUSY stall and a DONE pulse to the core control FSM. A timeout guards against hung units. It sits between the core's execute stage and the FP IP instances, replacing per-unit ad-hoc valid logic.

Parameters:
DATA_W, 32, operand/result width
NUM_UNITS, 7, number of FP units (index 0 ADDSUB, 1 MUL, 2 DIV, 3 COMP, 4 FCVTSW, 5 FCVTWS, 6 FSQRTS)
TIMEOUT_CYCLES, 1024, max cycles from SEND entry to result before abort
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
START  in  1  issue request, sampled only in IDLE
UNIT  in  3  target unit index
SUBOP  in  8  OP_TDATA value (ADDSUB: add 0x00, sub 0x01; COMP: eq 0x14, lt 0x0C, le 0x1C)
SRC_A  in  DATA_W  operand A
SRC_B  in  DATA_W  operand B
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse, RESULT valid
ERR  out  1  one-cycle pulse on timeout or illegal UNIT
RESULT  out  DATA_W  captured result, held until next DONE/ERR
A_TDATA, B_TDATA  out  DATA_W each  shared operand data to all units
OP_TDATA  out  8  shared op code (ADDSUB, COMP)
A_TVALID  out  NUM_UNITS  per-unit A valid
B_TVALID  out  NUM_UNITS  per-unit B valid (units 0-3 only; bits 4-6 tied 0)
OP_TVALID  out  NUM_UNITS  per-unit op valid (bits 0, 3 only)
A_TREADY, B_TREADY, OP_TREADY  in  NUM_UNITS each  per-unit channel readies
R_TDATA  in  NUM_UNITS*DATA_W  flattened results, unit i at [i*DATA_W +: DATA_W]
R_TVALID  in  NUM_UNITS  per-unit result valid
R_TREADY  out  NUM_UNITS  per-unit result ready

Behaviour:
- Reset: state IDLE. All TVALID/R_TREADY 0, BUSY/DONE/ERR 0, RESULT 0, TDATA 0, counter 0.
- All outputs registered. States: IDLE, SEND, WAIT, DONE, FAIL (one-hot).
- IDLE: START with UNIT<=6 latches UNIT/SUBOP/SRC_A/SRC_B and goes to SEND. Sets pending flags: A always; B for units 0-3; OP for units 0 and 3. START with UNIT==7 goes to FAIL, with no stream traffic.
- SEND: each pending channel's TVALID bit for the latched unit is high. A channel clears its pending flag and its valid on the cycle its TREADY is sampled high. TDATA is stable while valid. When all flags are clear (including those clearing this cycle) go to WAIT.
- WAIT: R_TREADY[unit]=1. On R_TVALID[unit]: capture R_TDATA slice into RESULT, drop R_TREADY, go to DONE.
- Only the latched unit's bits are ever asserted. R_TVALID from other units is ignored. R_TREADY is never high outside WAIT.
- DONE: DONE=1 for one cycle, then IDLE. BUSY drops in IDLE. START in DONE is ignored.
- Timeout: counter clears on SEND entry and increments each cycle in SEND/WAIT. Reaching TIMEOUT_CYCLES goes to FAIL: all valids/readies drop that cycle, RESULT=0.
- FAIL: ERR=1 for one cycle, then IDLE.
- Minimum latency, all readies high: START at t, valids at t+1, R_TREADY at t+2. R_TVALID at t+2 gives DONE at t+3 and IDLE at t+4.
- START while BUSY is ignored, with no queuing.
- RST mid-operation returns to the reset state next edge; valids drop regardless of handshake.

Decomposition:
- Shared package fpu_pkg: unit index constants (U_ADDSUB..U_FSQRTS), SUBOP code constants, per-unit operand-need masks (NEEDS_B, NEEDS_OP), state encoding.
- One sub-module: axis_src_hold, a single-channel valid/hold register with a load/clear on handshake. Instantiated for A, B, OP.

Test Plan:
- ADDSUB sub, all readies 1, SRC_A=0x40400000, SRC_B=0x3F800000, SUBOP=0x01. R_TVALID[0] is 1 at t+2 with data 0x40000000 → DONE at t+3, RESULT=0x40000000, only bit 0 of any valid/ready ever set.
- MUL with B_TREADY[1] low for 5 cycles, A_TREADY[1] high → A_TVALID[1] drops after 1 cycle, B_TVALID[1] held 6 cycles with stable B_TDATA, then WAIT.
- FSQRTS (unit 6) → B_TVALID and OP_TVALID stay 0 and the A-only handshake completes. R_TVALID[2] (stray) is ignored; R_TVALID[6] captures.
- TIMEOUT_CYCLES=16, DIV with R_TVALID never set → ERR pulse at cycle 17 after SEND entry, RESULT=0, R_TREADY[2] low, BUSY low next cycle.
- START with UNIT=7 → ERR next cycle, no TVALID asserted. Second START during WAIT is ignored (latched operands unchanged).
- RST asserted in SEND with A_TVALID[3] high → next cycle all outputs at reset values, state IDLE.
